alu_exec_unit: RTL

- Multi-cycle ALU execute unit; consumes the 3-bit ALUSel code produced by the ALU decoder.
- Add, sub, and, or and slt complete in one cycle.
- Shifts (sll, sllv, srav) run iteratively, one bit per cycle, behind a Start/Ready/Done handshake.
- Sits in the execute stage between register-file read and write-back.
- The ALU decoder is the producer of the ALUSel code; this block is its consumer.

---
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle ALU execute unit. It consumes the 3-bit ALUSel code from the
//   ALU decoder.
//   - add, sub, and, or and slt finish in one cycle.
//   - sll, sllv and srav shift one bit per cycle behind a Start/Ready/Done
//     handshake.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   Start     in   request pulse, accepted only while Ready=1
//   ALUSel    in   operation code, 3 bits:
//                    000 add, 001 sub, 010 and, 011 or,
//                    100 slt, 101 sll, 110 sllv, 111 srav
//   SrcA      in   operand A (rs), WIDTH bits
//   SrcB      in   operand B (rt), WIDTH bits
//   Shamt     in   immediate shift amount, SHAMT_W bits (sll only)
//   Ready     out  high while idle
//   Done      out  one-cycle pulse; Result, Zero and Overflow are valid
//   Result    out  registered result, WIDTH bits
//   Zero      out  registered (Result == 0)
//   Overflow  out  registered signed overflow for add/sub, 0 otherwise
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [2:0]         ALUSel,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Ready,
  output logic               Done,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Overflow
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SLLV = 3'b110;
  localparam logic [2:0] OP_SRAV = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q, op_d;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum_s;
  logic signed [WIDTH-1:0] diff_s;
  logic [SHAMT_W-1:0]      amt;
  logic [WIDTH-1:0]        shifted;

  // Add overflows when both operands share a sign the result does not.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Sub overflows when the operands differ in sign and the result sign
  // differs from the minuend.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_comb begin
    a_s    = SrcA;
    b_s    = SrcB;
    sum_s  = a_s + b_s;
    diff_s = a_s - b_s;
    // sll takes the immediate; sllv/srav take the low bits of rs.
    amt    = (ALUSel == OP_SLL) ? Shamt : SrcA[SHAMT_W-1:0];
    // One-bit step of the running shift; the captured opcode picks direction.
    if (op_q == OP_SRAV) begin
      shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    end else begin
      shifted = {result_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    op_d     = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = ALUSel;
          state_d = S_DONE;
          ovf_d   = 1'b0;
          unique case (ALUSel)
            OP_ADD: begin
              result_d = sum_s;
              ovf_d    = add_ovf(a_s, b_s, sum_s);
            end
            OP_SUB: begin
              result_d = diff_s;
              ovf_d    = sub_ovf(a_s, b_s, diff_s);
            end
            OP_AND:  result_d = SrcA & SrcB;
            OP_OR:   result_d = SrcA | SrcB;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: begin
              // Shifts start from rt; a zero amount completes immediately.
              result_d = SrcB;
              if (amt != '0) begin
                count_d = amt;
                state_d = S_SHIFT;
              end
            end
          endcase
          zero_d = (result_d == '0);
        end
      end
      S_SHIFT: begin
        result_d = shifted;
        count_d  = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          zero_d  = (shifted == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      op_q     <= OP_ADD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign Ready    = (state_q == S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule
